// File: rtl/piso_pkg.sv
// Shared types and constants for the piso_tx transmitter and its matching receiver.
package piso_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam int DEF_WIDTH      = 4;
  localparam int DEF_BIT_CYCLES = 1;
  localparam int DEF_GAP_CYCLES = 0;
  localparam int DEF_MSB_FIRST  = 1;

  // Counter width with a floor of one bit so degenerate ranges still synthesize.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/piso_tx_bit_tick_gen.sv
// Bit-period prescaler: tick is high on the last clock of each BIT_CYCLES period while enabled.
module bit_tick_gen
  import piso_pkg::*;
#(
  parameter int BIT_CYCLES = DEF_BIT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic en,
  output logic tick
);

  localparam int CW = cnt_w(BIT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(BIT_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/piso_tx.sv
// Parallel-in/serial-out transmitter with first/last framing strobes and an optional inter-frame gap.
// Handshake: a word transfers on a posedge where din_valid && din_ready; din is sampled only then.
module piso_tx
  import piso_pkg::*;
#(
  parameter int WIDTH      = DEF_WIDTH,
  parameter int BIT_CYCLES = DEF_BIT_CYCLES,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int MSB_FIRST  = DEF_MSB_FIRST
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             sout_first,
  output logic             sout_last,
  output logic             busy,
  output logic [1:0]       dbg_state
);

  localparam int BW = cnt_w(WIDTH);
  localparam int GW = cnt_w(GAP_CYCLES + 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);
  localparam logic [GW-1:0] GAP_LAST = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  state_t           state, state_n;
  logic [WIDTH-1:0] shreg, shreg_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic             tick, accept, frame_end;

  function automatic logic cur_bit(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_once(input logic [WIDTH-1:0] v);
    return (MSB_FIRST != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  bit_tick_gen #(.BIT_CYCLES(BIT_CYCLES)) u_tick (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .en    (state == SHIFT),
    .tick  (tick)
  );

  // Without a gap, the final cycle of the last bit doubles as an accept slot for back-to-back frames.
  assign frame_end = (state == SHIFT) && tick && (bit_cnt == BIT_LAST);
  assign din_ready = !reset && ((state == IDLE) || (frame_end && (GAP_CYCLES == 0)));
  assign accept    = din_valid && din_ready;
  assign dbg_state = state;

  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bit_n   = bit_cnt;
    gap_n   = gap_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          state_n = SHIFT;
          shreg_n = din;
          bit_n   = '0;
        end
      end
      SHIFT: begin
        if (tick) begin
          if (bit_cnt == BIT_LAST) begin
            if (accept) begin
              shreg_n = din;
              bit_n   = '0;
            end else if (GAP_CYCLES > 0) begin
              state_n = GAP;
              gap_n   = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            shreg_n = shift_once(shreg);
            bit_n   = bit_cnt + 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_cnt == GAP_LAST) state_n = IDLE;
        else gap_n = gap_cnt + 1'b1;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so the first bit appears right after the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      shreg      <= '0;
      bit_cnt    <= '0;
      gap_cnt    <= '0;
      sout       <= 1'b0;
      sout_valid <= 1'b0;
      sout_first <= 1'b0;
      sout_last  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_n;
      shreg      <= shreg_n;
      bit_cnt    <= bit_n;
      gap_cnt    <= gap_n;
      sout       <= (state_n == SHIFT) && cur_bit(shreg_n);
      sout_valid <= (state_n == SHIFT);
      sout_first <= (state_n == SHIFT) && (bit_n == '0);
      sout_last  <= (state_n == SHIFT) && (bit_n == BIT_LAST);
      busy       <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Bench for piso_tx: four instances cover MSB/LSB order, multi-cycle bits and an inter-frame gap.
module tb_piso_tx;

  localparam int N = 4;
  localparam int BC [N] = '{1, 1, 3, 1};
  localparam int MF [N] = '{1, 0, 1, 1};
  localparam int GC [N] = '{0, 0, 0, 2};

  logic           clk;
  logic [N-1:0]   rst, dv, rdy, so, sv, sf, sl, bz;
  logic [3:0]     din [N];
  logic [1:0]     st  [N];

  logic [2:0]     exp_q [N][$];
  logic [2:0]     e;
  int             total, bad;

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < N; g++) begin : g_dut
    piso_tx #(
      .WIDTH(4), .BIT_CYCLES(BC[g]), .GAP_CYCLES(GC[g]), .MSB_FIRST(MF[g])
    ) u_dut (
      .clk        (clk),
      .reset      (rst[g]),
      .din        (din[g]),
      .din_valid  (dv[g]),
      .din_ready  (rdy[g]),
      .sout       (so[g]),
      .sout_valid (sv[g]),
      .sout_first (sf[g]),
      .sout_last  (sl[g]),
      .busy       (bz[g]),
      .dbg_state  (st[g])
    );
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at %0t", name, got, want, $time);
    end
  endtask

  // order[3] is the first bit on the wire; each entry is {sout, sout_first, sout_last}
  task automatic push_frame(input int k, input logic [3:0] order, input int bc);
    for (int i = 0; i < 4; i++)
      for (int c = 0; c < bc; c++)
        exp_q[k].push_back({order[3-i], i == 0, i == 3});
  endtask

  // Called just after a negedge; returns 1 time unit after the accepting posedge.
  task automatic send(input int k, input logic [3:0] w, input logic hold);
    int n;
    n = 0;
    din[k] = w;
    dv[k]  = 1'b1;
    while (!rdy[k] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("send_timeout", 32'(n), 32'd0);
    @(posedge clk);
    #1;
    if (!hold) dv[k] = 1'b0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      if (sv[k]) begin
        total++;
        if (exp_q[k].size() == 0) begin
          bad++;
          $display("FAIL mon%0d_unexpected got=%b want=none at %0t", k, {so[k], sf[k], sl[k]}, $time);
        end else begin
          e = exp_q[k].pop_front();
          if ({so[k], sf[k], sl[k]} !== e) begin
            bad++;
            $display("FAIL mon%0d_bit got=%b want=%b at %0t", k, {so[k], sf[k], sl[k]}, e, $time);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt, gap, rdy_gap;
    total = 0;
    bad   = 0;
    rst   = '1;
    dv    = '0;
    for (int k = 0; k < N; k++) din[k] = 4'h0;

    // reset values
    repeat (2) @(negedge clk);
    for (int k = 0; k < N; k++) begin
      check("rst_ready", 32'(rdy[k]), 32'd0);
      check("rst_outs", 32'({so[k], sv[k], sf[k], sl[k], bz[k], st[k]}), 32'd0);
    end
    rst = '0;
    #1;
    for (int k = 0; k < N; k++) check("ready_after_rst", 32'(rdy[k]), 32'd1);
    @(negedge clk);

    // MSB first 1011 -> 1,0,1,1; ready only in final bit cycle
    push_frame(0, 4'b1011, 1);
    send(0, 4'hB, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 0) check("t1_first_latency", 32'({sv[0], sf[0], bz[0]}), 32'b111);
      check("t1_ready", 32'(rdy[0]), 32'(i == 3));
    end
    repeat (3) @(negedge clk);

    // LSB first 1011 -> 1,1,0,1
    push_frame(1, 4'b1101, 1);
    send(1, 4'hB, 1'b0);
    repeat (6) @(negedge clk);

    // three cycles per bit, 0110 -> 12 valid cycles
    push_frame(2, 4'b0110, 3);
    send(2, 4'h6, 1'b0);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      cnt += int'(sv[2]);
    end
    check("t3_valid_cycles", 32'(cnt), 32'd12);

    // back-to-back A then 5, no bubble
    push_frame(0, 4'b1010, 1);
    push_frame(0, 4'b0101, 1);
    send(0, 4'hA, 1'b1);
    din[0] = 4'h5;
    cnt = 0;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if (i == 4) dv[0] = 1'b0;
      if (i < 8) cnt += int'(sv[0]);
      else check("t4_idle_after", 32'({sv[0], bz[0]}), 32'd0);
    end
    check("t4_run_len", 32'(cnt), 32'd8);
    repeat (2) @(negedge clk);

    // two-cycle gap between frames
    push_frame(3, 4'b1010, 1);
    push_frame(3, 4'b0101, 1);
    send(3, 4'hA, 1'b1);
    din[3] = 4'h5;
    gap = 0;
    rdy_gap = 0;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      if (i == 7) dv[3] = 1'b0;
      if (bz[3] && !sv[3]) begin
        gap++;
        rdy_gap += int'(rdy[3]);
      end
    end
    check("t5_gap_cycles", 32'(gap), 32'd2);
    check("t5_ready_in_gap", 32'(rdy_gap), 32'd0);
    repeat (5) @(negedge clk);

    // din_valid pulse during SHIFT is ignored
    push_frame(0, 4'b0011, 1);
    send(0, 4'h3, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (i == 1) begin
        check("t6_ready_mid", 32'(rdy[0]), 32'd0);
        din[0] = 4'hF;
        dv[0]  = 1'b1;
      end
      if (i == 2) dv[0] = 1'b0;
    end
    repeat (2) @(negedge clk);
    push_frame(0, 4'b1100, 1);
    send(0, 4'hC, 1'b0);
    repeat (6) @(negedge clk);

    // reset during the third bit aborts the frame
    exp_q[0].push_back(3'b110);
    exp_q[0].push_back(3'b100);
    exp_q[0].push_back(3'b000);
    send(0, 4'hC, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i == 2) rst[0] = 1'b1;
    end
    @(negedge clk);
    check("t7_rst_outs", 32'({rdy[0], so[0], sv[0], sf[0], sl[0], bz[0], st[0]}), 32'd0);
    rst[0] = 1'b0;
    #1;
    check("t7_ready_after", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    push_frame(0, 4'b1001, 1);
    send(0, 4'h9, 1'b0);
    repeat (6) @(negedge clk);

    repeat (4) @(negedge clk);
    for (int k = 0; k < N; k++) check("queue_drained", 32'(exp_q[k].size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
